f_fetch_unit: RTL and testbench

F_FETCH_UNIT -- requirements
Module: f_fetch_unit

---
 rtl/f_fetch_unit.sv | 115 +++++++++++
 tb/tb_f_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: owns the fetch PC, drives the instruction-memory request
// and holds the F/D pipeline register, with a one-word buffer for stalled fetches.
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        im_req,
    output logic [31:0] im_addr,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_adel
);

    typedef enum logic {
        S_FETCH,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] dpc_q, dpc_d;
    logic [31:0] dinstr_q, dinstr_d;
    logic        dvalid_q, dvalid_d;
    logic        dadel_q, dadel_d;
    logic [31:0] hword_q, hword_d;
    logic        hadel_q, hadel_d;

    logic        aligned;
    logic        done;
    logic [31:0] word;

    assign aligned = (fpc_q[1:0] == 2'b00);
    // Request depends only on registered state, never on npc.
    assign im_req  = !reset && (state_q == S_FETCH) && aligned;
    assign im_addr = {fpc_q[31:2], 2'b00};
    assign done    = aligned ? (im_req && im_ack) : 1'b1;
    assign word    = aligned ? im_rdata : 32'h0;

    assign F_pc    = fpc_q;
    assign D_pc    = dpc_q;
    assign D_instr = dinstr_q;
    assign D_valid = dvalid_q;
    assign D_adel  = dadel_q;

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        dpc_d    = dpc_q;
        dinstr_d = dinstr_q;
        dvalid_d = dvalid_q;
        dadel_d  = dadel_q;
        hword_d  = hword_q;
        hadel_d  = hadel_q;
        unique case (state_q)
            S_FETCH: begin
                if (done && !stall) begin
                    dpc_d    = fpc_q;
                    dinstr_d = word;
                    dvalid_d = 1'b1;
                    dadel_d  = !aligned;
                    fpc_d    = npc;
                end else if (done) begin
                    hword_d  = word;
                    hadel_d  = !aligned;
                    state_d  = S_HOLD;
                end else if (!stall) begin
                    dinstr_d = 32'h0;
                    dvalid_d = 1'b0;
                    dadel_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    dpc_d    = fpc_q;
                    dinstr_d = hword_q;
                    dvalid_d = 1'b1;
                    dadel_d  = hadel_q;
                    fpc_d    = npc;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            fpc_q    <= RESET_PC;
            dpc_q    <= RESET_PC;
            dinstr_q <= 32'h0;
            dvalid_q <= 1'b0;
            dadel_q  <= 1'b0;
            hword_q  <= 32'h0;
            hadel_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            dpc_q    <= dpc_d;
            dinstr_q <= dinstr_d;
            dvalid_q <= dvalid_d;
            dadel_q  <= dadel_d;
            hword_q  <= hword_d;
            hadel_q  <= hadel_d;
        end
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: cycle vector table for the corner cases plus
// a scoreboarded zero-wait / random-ack instruction stream.
module tb_f_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] F_pc;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_adel;

    int checks = 0;
    int errors = 0;

    f_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk      (clk),
        .reset    (reset),
        .npc      (npc),
        .stall    (stall),
        .im_ack   (im_ack),
        .im_rdata (im_rdata),
        .im_req   (im_req),
        .im_addr  (im_addr),
        .F_pc     (F_pc),
        .D_pc     (D_pc),
        .D_instr  (D_instr),
        .D_valid  (D_valid),
        .D_adel   (D_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] nxt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_fpc;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic [31:0] e_di;
        logic        e_adel;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    vec_t vecs[18];
    sb_t  sbq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic do_reset();
        reset  = 1'b1;
        stall  = 1'b0;
        im_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        im_ack   = 1'b0;
        im_rdata = 32'h0;
        npc      = 32'h0000_3004;

        // rst stl ack rdata npc | req addr | fpc dv dpc di adel
        vecs[0]  = '{0,0,0,32'h0,32'h3004, 1,32'h3000, 32'h3000,0,32'h3000,32'h0,0};
        vecs[1]  = '{0,0,0,32'h0,32'h3004, 1,32'h3000, 32'h3000,0,32'h3000,32'h0,0};
        vecs[2]  = '{0,0,0,32'h0,32'h3004, 1,32'h3000, 32'h3000,0,32'h3000,32'h0,0};
        vecs[3]  = '{0,0,1,32'h1111_0000,32'h3004, 1,32'h3000,
                     32'h3004,1,32'h3000,32'h1111_0000,0};
        vecs[4]  = '{0,1,1,32'h2408_0001,32'h3008, 1,32'h3004,
                     32'h3004,1,32'h3000,32'h1111_0000,0};
        vecs[5]  = '{0,1,1,32'hDEAD_BEEF,32'h3008, 0,32'h3004,
                     32'h3004,1,32'h3000,32'h1111_0000,0};
        vecs[6]  = '{0,0,0,32'h0,32'h3008, 0,32'h3004,
                     32'h3008,1,32'h3004,32'h2408_0001,0};
        vecs[7]  = '{0,1,0,32'h0,32'h300C, 1,32'h3008,
                     32'h3008,1,32'h3004,32'h2408_0001,0};
        vecs[8]  = '{0,0,0,32'h0,32'h300C, 1,32'h3008,
                     32'h3008,0,32'h3004,32'h0,0};
        vecs[9]  = '{0,0,1,32'h1000_0010,32'h300C, 1,32'h3008,
                     32'h300C,1,32'h3008,32'h1000_0010,0};
        vecs[10] = '{0,0,1,32'h0000_AAAA,32'h3040, 1,32'h300C,
                     32'h3040,1,32'h300C,32'h0000_AAAA,0};
        vecs[11] = '{0,0,1,32'h0000_BBBB,32'h3044, 1,32'h3040,
                     32'h3044,1,32'h3040,32'h0000_BBBB,0};
        vecs[12] = '{0,0,1,32'h0000_CCCC,32'h3002, 1,32'h3044,
                     32'h3002,1,32'h3044,32'h0000_CCCC,0};
        vecs[13] = '{0,0,1,32'h0000_FFFF,32'h3010, 0,32'h3000,
                     32'h3010,1,32'h3002,32'h0,1};
        vecs[14] = '{0,0,0,32'h0,32'h3014, 1,32'h3010,
                     32'h3010,0,32'h3002,32'h0,0};
        vecs[15] = '{1,1,1,32'h5555_5555,32'h3014, 0,32'h3010,
                     32'h3000,0,32'h3000,32'h0,0};
        vecs[16] = '{0,0,0,32'h0,32'h3004, 1,32'h3000,
                     32'h3000,0,32'h3000,32'h0,0};
        vecs[17] = '{0,0,1,32'h1234_5678,32'h3004, 1,32'h3000,
                     32'h3004,1,32'h3000,32'h1234_5678,0};

        do_reset();
        chk("rst_req", {31'h0, im_req}, 32'h0);
        chk("rst_fpc", F_pc, 32'h3000);
        chk("rst_dpc", D_pc, 32'h3000);
        chk("rst_dinstr", D_instr, 32'h0);
        chk("rst_dvalid", {31'h0, D_valid}, 32'h0);
        chk("rst_dadel", {31'h0, D_adel}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            reset    = vecs[i].rst;
            stall    = vecs[i].stl;
            im_ack   = vecs[i].ack;
            im_rdata = vecs[i].rdata;
            npc      = vecs[i].nxt;
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, im_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), im_addr, vecs[i].e_addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_fpc", i), F_pc, vecs[i].e_fpc);
            chk($sformatf("v%0d_dv", i), {31'h0, D_valid}, {31'h0, vecs[i].e_dv});
            chk($sformatf("v%0d_dpc", i), D_pc, vecs[i].e_dpc);
            chk($sformatf("v%0d_di", i), D_instr, vecs[i].e_di);
            chk($sformatf("v%0d_adel", i), {31'h0, D_adel}, {31'h0, vecs[i].e_adel});
        end

        // Stall at completion of a misaligned fetch: adel must survive HOLD.
        npc = 32'h0000_3006;
        im_ack = 1'b1;
        im_rdata = memword(32'h3004);
        @(posedge clk);
        #1;
        stall = 1'b1;
        npc = 32'h0000_3008;
        @(posedge clk);
        #1;
        chk("hold_adel_req", {31'h0, im_req}, 32'h0);
        chk("hold_adel_dpc", D_pc, 32'h3004);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_adel_adel", {31'h0, D_adel}, 32'h1);
        chk("hold_adel_dpc2", D_pc, 32'h3006);
        chk("hold_adel_di", D_instr, 32'h0);
        chk("hold_adel_fpc", F_pc, 32'h3008);

        // Zero-wait stream then random acks, scoreboarded.
        begin
            logic [31:0] epc;
            sb_t e;
            do_reset();
            reset = 1'b0;
            epc = 32'h0000_3000;
            for (int c = 0; c < 40; c++) begin
                im_ack   = (c < 8) ? 1'b1 : 1'($urandom_range(0, 1));
                im_rdata = memword(im_addr);
                npc      = im_ack ? epc + 32'd4 : epc;
                #1;
                chk($sformatf("zw%0d_addr", c), im_addr, epc);
                if (im_ack) begin
                    sbq.push_back('{epc, memword(epc)});
                    epc = epc + 32'd4;
                end
                @(posedge clk);
                #1;
                chk($sformatf("zw%0d_dv", c), {31'h0, D_valid}, {31'h0, im_ack});
                if (D_valid) begin
                    if (sbq.size() == 0) begin
                        chk($sformatf("zw%0d_sb_empty", c), 32'h1, 32'h0);
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("zw%0d_dpc", c), D_pc, e.pc);
                        chk($sformatf("zw%0d_di", c), D_instr, e.instr);
                    end
                end
            end
            chk("zw_sb_drained", sbq.size(), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
